// File: rtl/greater_sweep_pkg.sv
// Shared definitions for the greater_sweep stimulus/capture stage:
// FSM state encodings and the default operand width and hold time.
package greater_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_HOLD  = 1;

endpackage

// File: rtl/hold_timer.sv
// Settle timer: cleared by load, counts while enabled, and flags expire
// once it has reached HOLD-1 (so an enabled window lasts HOLD cycles).
module hold_timer #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == LAST);

  // Saturates at HOLD-1 so a stalled enable never wraps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/greater_sweep.sv
// Walks every {a,b} operand pair into an external `greater' comparator and
// captures its answers as a truth table plus a count of ones.
// Optional feature macro: GREATER_SWEEP_SELF_CHECK_EN (mismatch_o, fail_idx_o).
module greater_sweep
  import greater_sweep_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int HOLD  = DEF_HOLD,
  localparam int IW    = 2 * WIDTH,
  localparam int N     = 1 << IW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  input  logic             gt_i,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     table_o,
  output logic [IW:0]      count_o
`ifdef GREATER_SWEEP_SELF_CHECK_EN
  ,
  output logic             mismatch_o,
  output logic [IW-1:0]    fail_idx_o
`endif
);

  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [IW-1:0] IDX_MAX = '1;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [N-1:0]    table_n;
  logic [IW:0]     count_n;
  logic            busy_n, done_n;
  logic            expire;

  assign a_o = idx[IW-1:WIDTH];
  assign b_o = idx[WIDTH-1:0];

  hold_timer #(.HOLD(HOLD)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state != ST_DRIVE),
    .en     (state == ST_DRIVE),
    .expire (expire)
  );

`ifdef GREATER_SWEEP_SELF_CHECK_EN
  logic            mismatch_n;
  logic [IW-1:0]   fail_idx_n;
`endif

  // Next-state and next-output logic; everything holds unless a state acts.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    table_n = table_o;
    count_n = count_o;
    busy_n  = busy;
    done_n  = done;
`ifdef GREATER_SWEEP_SELF_CHECK_EN
    mismatch_n = mismatch_o;
    fail_idx_n = fail_idx_o;
`endif
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_DRIVE;
          idx_n   = '0;
          table_n = '0;
          count_n = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
`ifdef GREATER_SWEEP_SELF_CHECK_EN
          mismatch_n = 1'b0;
          fail_idx_n = '0;
`endif
        end
      end
      ST_DRIVE: begin
        if (expire) state_n = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        table_n[idx] = gt_i;
        count_n      = count_o + {{IW{1'b0}}, gt_i};
`ifdef GREATER_SWEEP_SELF_CHECK_EN
        if (gt_i != (a_o > b_o)) begin
          mismatch_n = 1'b1;
          if (!mismatch_o) fail_idx_n = idx;
        end
`endif
        if (idx == IDX_MAX) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          idx_n   = idx + IDX_ONE;
          state_n = ST_DRIVE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // All outputs are registered; reset discards any partial sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      table_o <= '0;
      count_o <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef GREATER_SWEEP_SELF_CHECK_EN
      mismatch_o <= 1'b0;
      fail_idx_o <= '0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      table_o <= table_n;
      count_o <= count_n;
      busy    <= busy_n;
      done    <= done_n;
`ifdef GREATER_SWEEP_SELF_CHECK_EN
      mismatch_o <= mismatch_n;
      fail_idx_o <= fail_idx_n;
`endif
    end
  end

endmodule

// File: tb/tb_greater_sweep.sv
// Directed bench for greater_sweep: one HOLD=1 and one HOLD=3 instance,
// each beside a behavioural `greater' comparator.
module tb_greater_sweep;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic        force_one;
  logic [1:0]  a1, b1, a2, b2;
  logic        gt1, gt2;
  logic        busy1, done1, busy2, done2;
  logic [15:0] table1, table2;
  logic [4:0]  count1, count2;
`ifdef GREATER_SWEEP_SELF_CHECK_EN
  logic        mm1, mm2;
  logic [3:0]  fidx1, fidx2;
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  always #5 clk = ~clk;

  assign gt1 = force_one ? 1'b1 : (a1 > b1);
  assign gt2 = (a2 > b2);

  greater_sweep #(.WIDTH(2), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1), .gt_i(gt1),
    .busy(busy1), .done(done1), .table_o(table1), .count_o(count1)
`ifdef GREATER_SWEEP_SELF_CHECK_EN
    , .mismatch_o(mm1), .fail_idx_o(fidx1)
`endif
  );

  greater_sweep #(.WIDTH(2), .HOLD(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_o(a2), .b_o(b2), .gt_i(gt2),
    .busy(busy2), .done(done2), .table_o(table2), .count_o(count2)
`ifdef GREATER_SWEEP_SELF_CHECK_EN
    , .mismatch_o(mm2), .fail_idx_o(fidx2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pulses start on dut1 for the edge that accepts it.
  task automatic applyStimulus();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  // Counts edges until dut1 raises done, bounded so a stuck design still ends.
  task automatic waitDone1(input int already, output int n);
    n = already;
    while (!done1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; force_one = 1'b0;
    tick(); tick();
    checkOutput("reset_table",  32'(table1), 32'h0);
    checkOutput("reset_count",  32'(count1), 32'h0);
    checkOutput("reset_busy",   32'(busy1),  32'h0);
    checkOutput("reset_done",   32'(done1),  32'h0);
    checkOutput("reset_ab",     32'({a1, b1}), 32'h0);
    checkOutput("reset_busy2",  32'(busy2),  32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] test 1: basic sweep");
    applyStimulus();
    checkOutput("t1_busy_next", 32'(busy1), 32'h1);
    checkOutput("t1_done_low",  32'(done1), 32'h0);
    waitDone1(0, cyc);
    checkOutput("t1_done_cycle", 32'(cyc), 32'd32);
    checkOutput("t1_done",  32'(done1),  32'h1);
    checkOutput("t1_busy",  32'(busy1),  32'h0);
    checkOutput("t1_table", 32'(table1), 32'h7310);
    checkOutput("t1_count", 32'(count1), 32'd6);
`ifdef GREATER_SWEEP_SELF_CHECK_EN
    checkOutput("t1_mismatch", 32'(mm1), 32'h0);
`endif
    tick(); tick();
    checkOutput("t1_done_held",  32'(done1),  32'h1);
    checkOutput("t1_table_held", 32'(table1), 32'h7310);

    $display("[TB] test 2: HOLD=3 sweep");
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick(); tick();
    checkOutput("t2_ab_held", 32'({a2, b2}), 32'h0);
    tick();
    checkOutput("t2_ab_next", 32'({a2, b2}), 32'h1);
    cyc = 4;
    while (!done2 && cyc < 200) begin
      tick();
      cyc++;
    end
    checkOutput("t2_done_cycle", 32'(cyc), 32'd64);
    checkOutput("t2_table", 32'(table2), 32'h7310);
    checkOutput("t2_count", 32'(count2), 32'd6);

    $display("[TB] test 3: start ignored while busy");
    applyStimulus();
    for (int i = 0; i < 9; i++) tick();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("t3_busy_kept", 32'(busy1), 32'h1);
    waitDone1(10, cyc);
    checkOutput("t3_done_cycle", 32'(cyc), 32'd32);
    checkOutput("t3_table", 32'(table1), 32'h7310);
    checkOutput("t3_count", 32'(count1), 32'd6);

    $display("[TB] test 4: reset mid-sweep");
    applyStimulus();
    for (int i = 0; i < 12; i++) tick();
    checkOutput("t4_partial", 32'(table1), 32'h0010);
    rst = 1'b1;
    #1;
    checkOutput("t4_table", 32'(table1), 32'h0);
    checkOutput("t4_count", 32'(count1), 32'h0);
    checkOutput("t4_busy",  32'(busy1),  32'h0);
    checkOutput("t4_done",  32'(done1),  32'h0);
    checkOutput("t4_ab",    32'({a1, b1}), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus();
    waitDone1(0, cyc);
    checkOutput("t4_done_cycle", 32'(cyc), 32'd32);
    checkOutput("t4_table_new",  32'(table1), 32'h7310);

    $display("[TB] test 5: back-to-back sweeps");
    applyStimulus();
    checkOutput("t5_done_drop", 32'(done1),  32'h0);
    checkOutput("t5_busy",      32'(busy1),  32'h1);
    checkOutput("t5_table_clr", 32'(table1), 32'h0);
    checkOutput("t5_count_clr", 32'(count1), 32'h0);
    waitDone1(0, cyc);
    checkOutput("t5_done_cycle", 32'(cyc), 32'd32);
    checkOutput("t5_table", 32'(table1), 32'h7310);
    checkOutput("t5_count", 32'(count1), 32'd6);

    $display("[TB] test 6: comparator stuck at one");
    force_one = 1'b1;
    applyStimulus();
    waitDone1(0, cyc);
    checkOutput("t6_done_cycle", 32'(cyc), 32'd32);
    checkOutput("t6_table", 32'(table1), 32'hFFFF);
    checkOutput("t6_count", 32'(count1), 32'd16);
`ifdef GREATER_SWEEP_SELF_CHECK_EN
    checkOutput("t6_mismatch", 32'(mm1),   32'h1);
    checkOutput("t6_fail_idx", 32'(fidx1), 32'h0);
    force_one = 1'b0;
    applyStimulus();
    checkOutput("t6_mismatch_clr", 32'(mm1), 32'h0);
    waitDone1(0, cyc);
    checkOutput("t6_mismatch_clean", 32'(mm1), 32'h0);
`endif
    force_one = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
